// File: rtl/regfile_mp.sv
// Multi-port register file with a hard-wired zero register and a sequential clear engine.
// Optional build macro REGFILE_BYPASS_EN adds write-to-read forwarding in the same cycle.
module regfile_mp #(
  parameter int REG_WIDTH = 64,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = NUM_REGS - 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WRITE-1:0]          RegWrite,
  input  logic [NUM_WRITE*AW-1:0]       WriteRegister,
  input  logic [NUM_WRITE*REG_WIDTH-1:0] WriteData,
  input  logic [NUM_READ*AW-1:0]        ReadRegister,
  output logic [NUM_READ*REG_WIDTH-1:0] ReadData,
  input  logic                          Clear,
  output logic                          Busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       cnt_reg, cnt_next;
  logic                sweep_en;

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_en;
  logic [REG_WIDTH-1:0] wr_data [NUM_REGS];

  // Clear engine: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Clear engine: next state; counter wrap and return to idle coincide
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (Clear) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Clear engine: outputs
  always_comb begin
    sweep_en = (state_reg == ST_CLEAR);
    Busy     = sweep_en;
  end

  // Per-register write resolution; later ports override earlier ones
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_en[r]   = 1'b0;
      wr_data[r] = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (RegWrite[w] && (WriteRegister[w*AW +: AW] == AW'(r)) && (AW'(r) != ZERO_ADDR)) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = WriteData[w*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  // Storage: the sweep owns the array while it runs, so write ports are locked out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (sweep_en) begin
      regs[cnt_reg] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en[r]) begin
          regs[r] <= wr_data[r];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [AW-1:0]        addr;
      logic [REG_WIDTH-1:0] val;

      assign addr = ReadRegister[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
      always_comb begin
        val = regs[addr];
        if (!sweep_en) begin
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (RegWrite[w] && (WriteRegister[w*AW +: AW] == addr)) begin
              val = WriteData[w*REG_WIDTH +: REG_WIDTH];
            end
          end
        end
        if (addr == ZERO_ADDR) begin
          val = '0;
        end
      end
`else
      always_comb begin
        val = regs[addr];
        if (addr == ZERO_ADDR) begin
          val = '0;
        end
      end
`endif

      assign ReadData[gi*REG_WIDTH +: REG_WIDTH] = val;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

  localparam int RW  = 64;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam logic [63:0] K = 64'h0000010204080001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NWR-1:0]   RegWrite = '0;
  logic [NWR*AW-1:0] WriteRegister = '0;
  logic [NWR*RW-1:0] WriteData = '0;
  logic [NRD*AW-1:0] ReadRegister = '0;
  logic [NRD*RW-1:0] ReadData;
  logic             Clear = 1'b0;
  logic             Busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(
    .REG_WIDTH(RW),
    .NUM_REGS (NR),
    .NUM_READ (NRD),
    .NUM_WRITE(NWR),
    .ZERO_REG (NR - 1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .Clear        (Clear),
    .Busy         (Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd(input int p);
    return ReadData[p*RW +: RW];
  endfunction

  task automatic set_rd(input int p, input int a);
    ReadRegister[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input logic en, input int a, input logic [63:0] d);
    RegWrite[p] = en;
    WriteRegister[p*AW +: AW] = AW'(a);
    WriteData[p*RW +: RW] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [63:0] e1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b expected 0", Busy);
    end
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a);
      set_rd(1, NR - 1 - a);
      #1;
      e1 = 64'd0;
      n_checks++;
      if (rd(0) !== e1 || rd(1) !== e1) begin
        n_fail++;
        $display("FAIL reset_read a=%0d got %h/%h expected 0", a, rd(0), rd(1));
      end
    end
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write_read;
    logic [63:0] e0, e1;
    for (int i = 0; i < NR; i++) begin
      set_wr(0, 1'b1, i, 64'(i));
      set_wr(1, 1'b0, 0, 64'd0);
      tick();
    end
    RegWrite = '0;
    for (int i = 0; i < NR; i++) begin
      set_rd(0, i);
      set_rd(1, NR - 1 - i);
      #1;
      e0 = (i == NR - 1) ? 64'd0 : 64'(i);
      e1 = (i == 0) ? 64'd0 : 64'(NR - 1 - i);
      n_checks++;
      if (rd(0) !== e0 || rd(1) !== e1) begin
        n_fail++;
        $display("FAIL write_read i=%0d got %h/%h expected %h/%h", i, rd(0), rd(1), e0, e1);
      end
    end
    $display("test_write_read done");
  endtask

  task automatic test_conflict;
    set_wr(0, 1'b1, 7, 64'hAAAA);
    set_wr(1, 1'b1, 7, 64'h5555);
    tick();
    RegWrite = '0;
    set_rd(0, 7);
    set_rd(1, 8);
    #1;
    n_checks++;
    if (rd(0) !== 64'h5555) begin
      n_fail++;
      $display("FAIL conflict_r7 got %h expected %h", rd(0), 64'h5555);
    end
    n_checks++;
    if (rd(1) !== 64'd8) begin
      n_fail++;
      $display("FAIL conflict_r8 got %h expected %h", rd(1), 64'd8);
    end
    set_wr(0, 1'b1, 31, 64'hA0);
    tick();
    RegWrite = '0;
    set_rd(1, 31);
    #1;
    n_checks++;
    if (rd(1) !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_reg got %h expected 0", rd(1));
    end
    $display("test_conflict done");
  endtask

  task automatic test_clear;
    int cycles;
    logic [63:0] e1;
    for (int i = 0; i < NR - 1; i++) begin
      set_wr(0, 1'b1, i, 64'(i) * K);
      tick();
    end
    RegWrite = '0;
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle_busy got %b expected 0", Busy);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 64) begin
      if (cycles == 5) begin
        set_rd(0, 3);
        set_rd(1, 20);
        #1;
        e1 = 64'd20 * K;
        n_checks++;
        if (rd(0) !== 64'd0 || rd(1) !== e1) begin
          n_fail++;
          $display("FAIL clear_mid got %h/%h expected 0/%h", rd(0), rd(1), e1);
        end
        set_wr(0, 1'b1, 3, 64'hFF);
      end
      if (cycles == 10) Clear = 1'b1;
      tick();
      RegWrite = '0;
      Clear = 1'b0;
      cycles++;
    end
    n_checks++;
    if (cycles !== 32) begin
      n_fail++;
      $display("FAIL clear_len got %0d expected 32", cycles);
    end
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      #1;
      n_checks++;
      if (rd(0) !== 64'd0 || rd(1) !== 64'd0) begin
        n_fail++;
        $display("FAIL clear_after a=%0d got %h/%h expected 0", a, rd(0), rd(1));
      end
    end
    $display("test_clear done, busy cycles=%0d", cycles);
  endtask

  task automatic test_reset_mid_sweep;
    for (int i = 0; i < NR - 1; i++) begin
      set_wr(0, 1'b1, i, 64'(i + 100));
      tick();
    end
    RegWrite = '0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sweep_busy got %b expected 1", Busy);
    end
    set_rd(0, 15);
    set_rd(1, 25);
    reset = 1'b0;
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_busy got %b expected 0", Busy);
    end
    n_checks++;
    if (rd(0) !== 64'd0 || rd(1) !== 64'd0) begin
      n_fail++;
      $display("FAIL async_read got %h/%h expected 0", rd(0), rd(1));
    end
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a);
      #1;
      n_checks++;
      if (rd(0) !== 64'd0) begin
        n_fail++;
        $display("FAIL async_all a=%0d got %h expected 0", a, rd(0));
      end
    end
    tick();
    reset = 1'b1;
    set_wr(0, 1'b1, 2, 64'h12);
    tick();
    RegWrite = '0;
    set_rd(0, 2);
    #1;
    n_checks++;
    if (rd(0) !== 64'h12 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_write got %h busy=%b expected %h busy=0", rd(0), Busy, 64'h12);
    end
    $display("test_reset_mid_sweep done");
  endtask

  task automatic test_bypass;
    logic [63:0] e0;
    set_wr(0, 1'b1, 4, 64'h1111);
    tick();
    RegWrite = '0;
    set_wr(1, 1'b1, 4, 64'hBEEF);
    set_wr(0, 1'b1, 31, 64'h77);
    set_rd(0, 4);
    set_rd(1, 31);
    #1;
`ifdef REGFILE_BYPASS_EN
    e0 = 64'hBEEF;
`else
    e0 = 64'h1111;
`endif
    n_checks++;
    if (rd(0) !== e0) begin
      n_fail++;
      $display("FAIL bypass_pre got %h expected %h", rd(0), e0);
    end
    n_checks++;
    if (rd(1) !== 64'd0) begin
      n_fail++;
      $display("FAIL bypass_zero got %h expected 0", rd(1));
    end
    tick();
    RegWrite = '0;
    #1;
    n_checks++;
    if (rd(0) !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL bypass_post got %h expected %h", rd(0), 64'hBEEF);
    end
    $display("test_bypass done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_clear();
    test_reset_mid_sweep();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
